fv_bank_ctrl_gen: RTL and testbench

Parametrised feature-value (FV) SRAM bank controller. It arbitrates one single-port SRAM bank between three traffic types: per-replay-iteration streaming of node feature lines to the small-FV buffer, multi-beat write-back from the accumulator/vertex path, and node reads returned to a tagged Edge PE. Compared with the fixed 8-line bank controller it adds:

- configurable line geometry;
- a valid/ready request handshake;
- gap-tolerant write bursts;
- line-count clamping;
- valid strobes on both output streams;
- a sticky protocol-error flag.

---
 rtl/fv_bank_ctrl_gen.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_fv_bank_ctrl_gen.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fv_bank_ctrl_gen.sv
// fv_bank_ctrl_gen: feature-value SRAM bank controller.
// One single-port SRAM bank is shared between three traffic types:
//   - per-iteration streaming of node feature lines to the small-FV buffer,
//   - multi-beat write-back from the accumulator/vertex path,
//   - node reads returned to a tagged Edge PE.
// Ports:
//   clk, reset           clock, synchronous active-low reset
//   cur_iter_i           current replay iteration
//   stream_en_i          streaming phase enable
//   fv_num_i             feature values per node (sets lines per transfer)
//   req_*                valid/ready request channel (read or write-back)
//   sram_*               single-port SRAM (active-low CEN/WEN, 1-cycle read)
//   sm_*                 stream beats to the small-FV buffer
//   pe_*                 read beats to the Edge PE named by pe_tag_o
//   err_o                sticky protocol error
module fv_bank_ctrl_gen #(
  parameter int DATA_W         = 128,
  parameter int VALS_PER_LINE  = 2,
  parameter int LINES_PER_NODE = 8,
  parameter int NODES_PER_ITER = 4,
  parameter int MAX_ITER       = 4,
  parameter int NUM_PE         = 4,
  parameter int FVNUM_W        = 5,
  localparam int NODE_W = $clog2(MAX_ITER * NODES_PER_ITER),
  localparam int ADDR_W = NODE_W + $clog2(LINES_PER_NODE),
  localparam int LINE_W = $clog2(LINES_PER_NODE) + 1,
  localparam int ITER_W = $clog2(MAX_ITER),
  localparam int TAG_W  = $clog2(NUM_PE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ITER_W-1:0] cur_iter_i,
  input  logic              stream_en_i,
  input  logic [FVNUM_W-1:0] fv_num_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_rd_wr_i,
  input  logic [NODE_W-1:0] req_node_id_i,
  input  logic [TAG_W-1:0]  req_pe_tag_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic              req_wr_eos_i,
  output logic              sram_cen_o,
  output logic              sram_wen_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  input  logic [DATA_W-1:0] sram_rdata_i,
  output logic              sm_valid_o,
  output logic              sm_sos_o,
  output logic              sm_eos_o,
  output logic [ADDR_W-1:0] sm_addr_o,
  output logic [DATA_W-1:0] sm_data_o,
  output logic              pe_valid_o,
  output logic              pe_sos_o,
  output logic              pe_eos_o,
  output logic [TAG_W-1:0]  pe_tag_o,
  output logic [DATA_W-1:0] pe_data_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, STREAM, WB, RD} state_t;

  localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);
  localparam logic [NODE_W-1:0] NODE_ONE = NODE_W'(1);

  state_t            state;
  logic [LINE_W-1:0] cnt;
  logic [LINE_W-1:0] lines;
  logic [NODE_W-1:0] ncnt;
  logic [NODE_W-1:0] node_q;
  logic [TAG_W-1:0]  tag_q;
  logic [ITER_W-1:0] last_iter;
  logic              streamed_once;
  // Set once the final read of a stream/read burst is issued; the next
  // cycle only presents the last beat and then returns to IDLE.
  logic              draining;

  logic [31:0]       l_tmp;
  logic [LINE_W-1:0] l_new;
  logic              trigger;
  logic              accept;
  logic              cen, wen;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              sm_issue, sm_first, sm_last;
  logic [ADDR_W-1:0] sm_idx;
  logic              pe_issue, pe_first, pe_last;
  logic [TAG_W-1:0]  pe_tag_next;
  logic              wb_drop;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [NODE_W-1:0] node,
                                                  input logic [LINE_W-1:0] k);
    return ADDR_W'(node) * ADDR_W'(LINES_PER_NODE) + ADDR_W'(k);
  endfunction

  // Lines per transfer: ceil(fv/VALS_PER_LINE), at least 1, at most a node.
  always_comb begin
    l_tmp = (32'(fv_num_i) + 32'(VALS_PER_LINE) - 32'd1) / 32'(VALS_PER_LINE);
    if (l_tmp == 32'd0) begin
      l_new = LINE_ONE;
    end else if (l_tmp > 32'(LINES_PER_NODE)) begin
      l_new = LINE_W'(LINES_PER_NODE);
    end else begin
      l_new = l_tmp[LINE_W-1:0];
    end
  end

  // Streaming has priority and runs once per iteration value.
  assign trigger     = stream_en_i && (!streamed_once || (cur_iter_i != last_iter));
  assign req_ready_o = reset && (((state == IDLE) && !trigger) || (state == WB));
  assign accept      = req_valid_i && req_ready_o;

  // SRAM command for this cycle plus the beat qualifiers it will produce.
  always_comb begin
    cen         = 1'b1;
    wen         = 1'b1;
    addr        = '0;
    wdata       = '0;
    sm_issue    = 1'b0;
    sm_first    = 1'b0;
    sm_last     = 1'b0;
    sm_idx      = '0;
    pe_issue    = 1'b0;
    pe_first    = 1'b0;
    pe_last     = 1'b0;
    pe_tag_next = '0;
    wb_drop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (trigger) begin
          cen      = 1'b0;
          addr     = line_addr(NODE_W'(cur_iter_i) * NODE_W'(NODES_PER_ITER), '0);
          sm_issue = 1'b1;
          sm_first = 1'b1;
          sm_last  = (NODES_PER_ITER == 1) && (l_new == LINE_ONE);
        end else if (accept && req_rd_wr_i) begin
          cen   = 1'b0;
          wen   = 1'b0;
          addr  = line_addr(req_node_id_i, '0);
          wdata = req_data_i;
        end else if (accept) begin
          cen         = 1'b0;
          addr        = line_addr(req_node_id_i, '0);
          pe_issue    = 1'b1;
          pe_first    = 1'b1;
          pe_last     = (l_new == LINE_ONE);
          pe_tag_next = req_pe_tag_i;
        end
      end
      STREAM: begin
        if (!draining) begin
          cen      = 1'b0;
          addr     = line_addr(NODE_W'(last_iter) * NODE_W'(NODES_PER_ITER) + ncnt, cnt);
          sm_issue = 1'b1;
          sm_idx   = line_addr(ncnt, cnt);
          sm_last  = (ncnt == NODE_W'(NODES_PER_ITER - 1)) && (cnt == lines - LINE_ONE);
        end
      end
      WB: begin
        if (req_valid_i) begin
          if (!req_rd_wr_i || (cnt == LINE_W'(LINES_PER_NODE))) begin
            wb_drop = 1'b1;
          end else begin
            cen   = 1'b0;
            wen   = 1'b0;
            addr  = line_addr(node_q, cnt);
            wdata = req_data_i;
          end
        end
      end
      RD: begin
        if (!draining) begin
          cen         = 1'b0;
          addr        = line_addr(node_q, cnt);
          pe_issue    = 1'b1;
          pe_last     = (cnt == lines - LINE_ONE);
          pe_tag_next = tag_q;
        end
      end
      default: ;
    endcase
    // Keep the SRAM quiet while reset is held.
    if (!reset) begin
      cen      = 1'b1;
      wen      = 1'b1;
      addr     = '0;
      wdata    = '0;
      sm_issue = 1'b0;
      pe_issue = 1'b0;
      wb_drop  = 1'b0;
    end
  end

  assign sram_cen_o   = cen;
  assign sram_wen_o   = wen;
  assign sram_addr_o  = addr;
  assign sram_wdata_o = wdata;

  // Read data arrives one cycle after issue, aligned with the registered strobes.
  assign sm_data_o = sm_valid_o ? sram_rdata_i : '0;
  assign pe_data_o = pe_valid_o ? sram_rdata_i : '0;

  // Controller state, counters and registered beat strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      lines         <= '0;
      ncnt          <= '0;
      node_q        <= '0;
      tag_q         <= '0;
      last_iter     <= '0;
      streamed_once <= 1'b0;
      draining      <= 1'b0;
      err_o         <= 1'b0;
      sm_valid_o    <= 1'b0;
      sm_sos_o      <= 1'b0;
      sm_eos_o      <= 1'b0;
      sm_addr_o     <= '0;
      pe_valid_o    <= 1'b0;
      pe_sos_o      <= 1'b0;
      pe_eos_o      <= 1'b0;
      pe_tag_o      <= '0;
    end else begin
      sm_valid_o <= sm_issue;
      sm_sos_o   <= sm_issue && sm_first;
      sm_eos_o   <= sm_issue && sm_last;
      sm_addr_o  <= sm_issue ? sm_idx : '0;
      pe_valid_o <= pe_issue;
      pe_sos_o   <= pe_issue && pe_first;
      pe_eos_o   <= pe_issue && pe_last;
      pe_tag_o   <= pe_issue ? pe_tag_next : '0;
      if (wb_drop) begin
        err_o <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (trigger) begin
            streamed_once <= 1'b1;
            last_iter     <= cur_iter_i;
            lines         <= l_new;
            draining      <= sm_last;
            if (l_new == LINE_ONE) begin
              ncnt <= NODE_ONE;
              cnt  <= '0;
            end else begin
              ncnt <= '0;
              cnt  <= LINE_ONE;
            end
            state <= STREAM;
          end else if (accept && req_rd_wr_i) begin
            node_q <= req_node_id_i;
            cnt    <= LINE_ONE;
            if (!req_wr_eos_i) begin
              state <= WB;
            end
          end else if (accept) begin
            node_q   <= req_node_id_i;
            tag_q    <= req_pe_tag_i;
            lines    <= l_new;
            cnt      <= LINE_ONE;
            draining <= pe_last;
            state    <= RD;
          end
        end
        STREAM: begin
          if (draining) begin
            draining <= 1'b0;
            state    <= IDLE;
          end else if (sm_last) begin
            draining <= 1'b1;
          end else if (cnt == lines - LINE_ONE) begin
            ncnt <= ncnt + NODE_ONE;
            cnt  <= '0;
          end else begin
            cnt <= cnt + LINE_ONE;
          end
        end
        WB: begin
          if (req_valid_i) begin
            if (!wb_drop) begin
              cnt <= cnt + LINE_ONE;
            end
            if (req_wr_eos_i) begin
              state <= IDLE;
            end
          end
        end
        RD: begin
          if (draining) begin
            draining <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + LINE_ONE;
            if (pe_last) begin
              draining <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fv_bank_ctrl_gen.sv
// Self-checking bench for fv_bank_ctrl_gen with default parameters.
// A bench-side SRAM serves the DUT; an independent reference memory and
// transfer model predicts every beat, write and strobe.
module tb_fv_bank_ctrl_gen;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   cur_iter;
  logic         stream_en;
  logic [4:0]   fv_num;
  logic         req_valid;
  logic         req_ready;
  logic         req_rd_wr;
  logic [3:0]   req_node_id;
  logic [1:0]   req_pe_tag;
  logic [127:0] req_data;
  logic         req_wr_eos;
  logic         sram_cen, sram_wen;
  logic [6:0]   sram_addr;
  logic [127:0] sram_wdata;
  logic [127:0] sram_rdata = '0;
  logic         sm_valid, sm_sos, sm_eos;
  logic [6:0]   sm_addr;
  logic [127:0] sm_data;
  logic         pe_valid, pe_sos, pe_eos;
  logic [1:0]   pe_tag;
  logic [127:0] pe_data;
  logic         err;

  int checks = 0;
  int errors = 0;
  logic [127:0] ref_mem [128];
  logic [127:0] sram_mem [128];
  bit           written [128];
  bit           err_exp;
  int           model_iter;

  fv_bank_ctrl_gen dut (
    .clk(clk), .reset(reset), .cur_iter_i(cur_iter), .stream_en_i(stream_en),
    .fv_num_i(fv_num), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_rd_wr_i(req_rd_wr), .req_node_id_i(req_node_id), .req_pe_tag_i(req_pe_tag),
    .req_data_i(req_data), .req_wr_eos_i(req_wr_eos), .sram_cen_o(sram_cen),
    .sram_wen_o(sram_wen), .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata),
    .sram_rdata_i(sram_rdata), .sm_valid_o(sm_valid), .sm_sos_o(sm_sos),
    .sm_eos_o(sm_eos), .sm_addr_o(sm_addr), .sm_data_o(sm_data),
    .pe_valid_o(pe_valid), .pe_sos_o(pe_sos), .pe_eos_o(pe_eos),
    .pe_tag_o(pe_tag), .pe_data_o(pe_data), .err_o(err)
  );

  always #5 clk = ~clk;

  // Power-up contents of every line, distinct per address.
  function automatic logic [127:0] pat(input int a);
    logic [31:0] h;
    h = (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    return {h, ~h, h + 32'd7, 32'(a)};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Lines moved per node for a given feature count.
  function automatic int lines_for(input int fv);
    int l;
    l = fv / 2 + fv % 2;
    if (l < 1) l = 1;
    if (l > 8) l = 8;
    return l;
  endfunction

  // Single-port SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) begin
        sram_mem[sram_addr] <= sram_wdata;
        written[sram_addr]  <= 1'b1;
      end else begin
        sram_rdata <= written[sram_addr] ? sram_mem[sram_addr] : pat(int'(sram_addr));
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Stream one iteration; optionally present a competing read request in the
  // trigger cycle, or pull reset low right after beat abort_at.
  task automatic applyStream(input int iter, input int fv, input bit arb, input int abort_at);
    int l, n, k;
    l = lines_for(fv);
    @(negedge clk);
    reset = 1'b1;
    stream_en = 1'b1;
    cur_iter = 2'(iter);
    fv_num = 5'(fv);
    if (arb) begin
      req_valid = 1'b1;
      req_rd_wr = 1'b0;
    end
    #1;
    checkOutput("st_ready_low", req_ready, 0);
    checkOutput("st_cen0", sram_cen, 0);
    checkOutput("st_addr0", sram_addr, iter * 32);
    model_iter = iter;
    for (int b = 0; b < 4 * l; b++) begin
      @(negedge clk); #1;
      n = b / l;
      k = b % l;
      checkOutput("sm_valid", sm_valid, 1);
      checkOutput("sm_sos", sm_sos, (b == 0));
      checkOutput("sm_eos", sm_eos, (b == 4 * l - 1));
      checkOutput("sm_addr", sm_addr, n * 8 + k);
      checkOutput("sm_data", sm_data, ref_mem[(iter * 4 + n) * 8 + k]);
      checkOutput("st_pe_quiet", pe_valid, 0);
      checkOutput("st_ready", req_ready, 0);
      if (b + 1 == abort_at) begin
        reset = 1'b0;
        return;
      end
    end
    @(negedge clk); #1;
    checkOutput("st_done_valid", sm_valid, 0);
    checkOutput("st_done_ready", req_ready, 1);
  endtask

  // Edge PE read; with pre set the request is already being accepted.
  task automatic applyRead(input int node, input int tag, input int fv, input bit pre);
    int l;
    l = lines_for(fv);
    if (!pre) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_rd_wr = 1'b0;
      req_node_id = 4'(node);
      req_pe_tag = 2'(tag);
      req_wr_eos = 1'b0;
      fv_num = 5'(fv);
      #1;
    end
    checkOutput("rd_ready", req_ready, 1);
    checkOutput("rd_cen0", sram_cen, 0);
    checkOutput("rd_addr0", sram_addr, node * 8);
    for (int b = 0; b < l; b++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      checkOutput("pe_valid", pe_valid, 1);
      checkOutput("pe_sos", pe_sos, (b == 0));
      checkOutput("pe_eos", pe_eos, (b == l - 1));
      checkOutput("pe_tag", pe_tag, tag);
      checkOutput("pe_data", pe_data, ref_mem[node * 8 + b]);
      checkOutput("rd_sm_quiet", sm_valid, 0);
      checkOutput("rd_ready_low", req_ready, 0);
    end
    @(negedge clk); #1;
    checkOutput("rd_done_valid", pe_valid, 0);
    checkOutput("rd_done_ready", req_ready, 1);
  endtask

  // Write-back burst; gap_after inserts one idle cycle after that beat index.
  task automatic applyWrite(input int node, input int nbeats, input int gap_after);
    logic [127:0] d;
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      d = rand128();
      req_valid = 1'b1;
      req_rd_wr = 1'b1;
      req_node_id = 4'(node);
      req_data = d;
      req_wr_eos = (b == nbeats - 1);
      #1;
      checkOutput("wr_ready", req_ready, 1);
      if (b < 8) begin
        checkOutput("wr_cen", sram_cen, 0);
        checkOutput("wr_wen", sram_wen, 0);
        checkOutput("wr_addr", sram_addr, node * 8 + b);
        checkOutput("wr_data", sram_wdata, d);
        ref_mem[node * 8 + b] = d;
      end else begin
        checkOutput("wr_overflow_cen", sram_cen, 1);
        err_exp = 1'b1;
      end
      if (b == gap_after) begin
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checkOutput("wr_gap_cen", sram_cen, 1);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_wr_eos = 1'b0;
    #1;
    checkOutput("wr_err", err, err_exp);
    checkOutput("wr_done_ready", req_ready, 1);
  endtask

  initial begin
    int op, it;
    for (int i = 0; i < 128; i++) ref_mem[i] = pat(i);
    reset = 1'b0;
    cur_iter = '0;
    stream_en = 1'b0;
    fv_num = '0;
    req_valid = 1'b0;
    req_rd_wr = 1'b0;
    req_node_id = '0;
    req_pe_tag = '0;
    req_data = '0;
    req_wr_eos = 1'b0;
    err_exp = 1'b0;
    model_iter = 0;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_cen", sram_cen, 1);
    checkOutput("rst_wen", sram_wen, 1);
    checkOutput("rst_sm_valid", sm_valid, 0);
    checkOutput("rst_pe_valid", pe_valid, 0);
    checkOutput("rst_err", err, 0);
    @(negedge clk);
    reset = 1'b1;

    applyStream(1, 6, 1'b0, 0);
    applyRead(5, 2, 16, 1'b0);
    applyWrite(3, 4, 1);
    applyRead(3, 0, 8, 1'b0);
    applyRead(7, 1, 0, 1'b0);
    applyRead(9, 3, 31, 1'b0);
    applyStream(2, 0, 1'b0, 0);
    applyWrite(6, 9, -1);
    applyRead(6, 1, 16, 1'b0);

    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        it = (model_iter + $urandom_range(1, 3)) % 4;
        applyStream(it, $urandom_range(0, 31), 1'b0, 0);
      end else if (op == 1) begin
        applyRead($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 31), 1'b0);
      end else begin
        it = $urandom_range(1, 8);
        applyWrite($urandom_range(0, 15), it,
                   ($urandom_range(0, 1) == 1) ? $urandom_range(0, it - 1) : -1);
      end
    end

    // Stream and read request collide: stream first, read accepted afterwards.
    req_node_id = 4'd11;
    req_pe_tag = 2'd3;
    it = (model_iter + 1) % 4;
    applyStream(it, 10, 1'b1, 0);
    applyRead(11, 3, 10, 1'b1);
    repeat (3) begin
      @(negedge clk); #1;
      checkOutput("no_restream", sm_valid, 0);
    end

    // Reset during a stream, then the same iteration streams again.
    it = (model_iter + 1) % 4;
    applyStream(it, 6, 1'b0, 5);
    @(negedge clk); #1;
    err_exp = 1'b0;
    checkOutput("mid_rst_sm_valid", sm_valid, 0);
    checkOutput("mid_rst_sm_sos", sm_sos, 0);
    checkOutput("mid_rst_sm_eos", sm_eos, 0);
    checkOutput("mid_rst_sm_addr", sm_addr, 0);
    checkOutput("mid_rst_sm_data", sm_data, 0);
    checkOutput("mid_rst_pe_valid", pe_valid, 0);
    checkOutput("mid_rst_err", err, 0);
    checkOutput("mid_rst_ready", req_ready, 0);
    checkOutput("mid_rst_cen", sram_cen, 1);
    checkOutput("mid_rst_addr", sram_addr, 0);
    applyStream(it, 6, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
